dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
Parametrised successor to the DMA controller's priority-logic function. It arbitrates N DMA channels and runs the HRQ/HLDA bus handshake with the host. It drives one-hot DACK to the winning channel. Over the original it adds: programmable fixed/rotating priority, per-channel mask, software requests, selectable DREQ/DACK polarity, and a host-abort path. It sits between the bus interface pins and the timing-and-control block, which reports end of service.

Parameters:
CHANNELS, 4, number of DMA channels (2..16); also defined in dmaRegConfigPkg.
CHW, $clog2(CHANNELS), width of a channel index.

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous reset, active-high
DREQ  input  CHANNELS  channel requests, raw pin level
HLDA  input  1  host hold acknowledge
srvDone  input  1  one-cycle pulse from timing/control: current service finished (TC or EOP_N)
rotatePri  input  1  command reg: 0 = fixed priority (ch0 highest), 1 = rotating
dreqActiveLow  input  1  command reg: DREQ polarity
dackActiveHigh  input  1  command reg: DACK polarity
ctrlDisable  input  1  command reg: controller disable
maskReg  input  CHANNELS  1 = channel masked
swReq  input  CHANNELS  software request bits (not maskable, as in 8237)
HRQ  output  1  hold request to host
DACK  output  CHANNELS  channel acknowledge, polarity per dackActiveHigh
activeCh  output  CHW  index of the granted channel
grantValid  output  1  high while in GRANT

Behaviour:
- Effective request: eff = ((DREQ ^ {CHANNELS{dreqActiveLow}}) & ~maskReg) | swReq. This is combinational and sampled every CLK rising edge.
- Internal registered one-hot grant is gnt.
- DACK = dackActiveHigh ? gnt : ~gnt. DACK is therefore always at the inactive level when gnt == 0.
- Reset values (asynchronous, while RESET=1): state IDLE, HRQ 0, gnt 0 (DACK inactive), activeCh 0, grantValid 0, topPri 0.
- State machine with states IDLE, REQ, GRANT, RELEASE. All outputs are registered.
- IDLE: if eff != 0 and !ctrlDisable, go to REQ with HRQ = 1 on the next edge.
- REQ:
  - HLDA=1 and eff != 0: resolve the winner from eff at this edge, load gnt/activeCh, set grantValid=1, go to GRANT. DACK becomes active one cycle after HLDA is first sampled high.
  - HLDA=0 and eff == 0: drop HRQ, go to IDLE (request withdrawn).
  - HLDA=1 and eff == 0: go to RELEASE.
  - ctrlDisable is ignored once in REQ.
- GRANT:
  - HRQ stays 1 and gnt is held regardless of DREQ changes (block-mode semantics; demand handling belongs to timing/control).
  - srvDone=1: gnt 0, HRQ 0, grantValid 0, go to RELEASE. If rotatePri=1, topPri <= (activeCh+1) mod CHANNELS.
  - HLDA=0 (host abort): gnt 0, HRQ 0, grantValid 0, go to IDLE. topPri is unchanged.
  - srvDone and HLDA falling in the same cycle: treated as srvDone (rotation applied), next state IDLE.
- RELEASE: HRQ 0. Stay until HLDA=0, then go to IDLE. A new HRQ is never raised before HLDA is seen low, so the minimum HRQ-low time is one cycle.
- Priority resolution:
  - Fixed mode: lowest index in eff wins.
  - Rotating mode: first set bit scanning from topPri upward with wrap-around (topPri, topPri+1, ..., CHANNELS-1, 0, ...).
  - topPri is kept while in fixed mode. Switching modes takes effect at the next resolution.
- Index arithmetic is CHW bits. Wrap uses an explicit compare to CHANNELS-1 so that non-power-of-2 CHANNELS work.
- Changing maskReg during GRANT does not revoke the grant.

Decomposition:
- dmaRegConfigPkg gains:
  - CHANNELS and CHW constants.
  - typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} arbState_t.
  - typedef enum logic {FIXED, ROTATE} priMode_t.
- One sub-module, dma_rr_priority_encoder: combinational. Inputs eff, topPri, mode. Outputs winner index and valid.
- The busInterface priorityLogic modport is extended to carry HRQ/DACK with the new width.

Test Plan:
- Reset mid-GRANT (ch2 granted, RESET pulsed asynchronously mid-cycle) -> HRQ=0 and DACK=4'b0000 immediately (dackActiveHigh=1), state IDLE, topPri=0.
- Fixed mode, DREQ=4'b1010, HLDA raised 3 cycles after HRQ -> DACK=4'b0010 exactly one cycle after HLDA is sampled, activeCh=1.
- Rotating mode, all DREQ held high, srvDone after each grant, HLDA cycled -> grant order 0,1,2,3,0; HRQ low at least one cycle between grants.
- maskReg=4'b0001, DREQ=4'b0001, swReq=0 -> HRQ stays 0; then swReq=4'b0001 -> HRQ=1 next cycle and ch0 is granted despite the mask.
- dreqActiveLow=1, dackActiveHigh=0, DREQ=4'b1011 -> ch2 requests; grant gives DACK=4'b1011.
- Host abort: in GRANT on ch3, drop HLDA -> next cycle DACK inactive, HRQ=0, state IDLE, topPri unchanged. Same with simultaneous srvDone -> topPri=0 (wrapped from ch3).

Source files
------------

// File: rtl/dma_priority_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmaRegConfigPkg
//  Brief    : Shared constants and types for the DMA priority arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package dmaRegConfigPkg;

    // Default channel count and the matching channel-index width.
    localparam int CHANNELS = 4;
    localparam int CHW      = $clog2(CHANNELS);

    // Bus-handshake states of the arbiter.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arbState_t;

    // Priority scheme selected by the command register.
    typedef enum logic {
        FIXED  = 1'b0,
        ROTATE = 1'b1
    } priMode_t;

endpackage : dmaRegConfigPkg
`default_nettype wire

// File: rtl/dma_priority_arbiter_rr_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : dma_rr_priority_encoder
//  Brief    : Picks the winning channel from the effective request vector,
//             either lowest index first or scanning upward from topPri with
//             wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_rr_priority_encoder
    import dmaRegConfigPkg::*;
#(
    parameter int CHANNELS = dmaRegConfigPkg::CHANNELS,
    parameter int CHW      = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_eff,
    input  logic [CHW-1:0]      i_top_pri,
    input  priMode_t            i_mode,
    output logic [CHW-1:0]      o_winner,
    output logic                o_valid
);

    // Explicit last-index compare keeps the wrap correct for non-power-of-2 counts.
    localparam logic [CHW-1:0] C_LAST = CHW'(CHANNELS - 1);

    logic [CHW-1:0] w_scan_idx;

    // Walk every channel once from the start point; the first requester wins.
    always_comb begin
        w_scan_idx = (i_mode == ROTATE) ? i_top_pri : '0;
        o_winner   = '0;
        o_valid    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!o_valid && i_eff[w_scan_idx]) begin
                o_winner = w_scan_idx;
                o_valid  = 1'b1;
            end
            w_scan_idx = (w_scan_idx == C_LAST) ? '0 : w_scan_idx + 1'b1;
        end
    end

endmodule : dma_rr_priority_encoder
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dma_priority_arbiter
//  Brief    : Arbitrates N DMA channels, runs the HRQ/HLDA hold handshake and
//             drives a one-hot DACK to the winner. Fixed or rotating priority,
//             per-channel mask, software requests, selectable pin polarity,
//             host-abort on HLDA loss.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter
    import dmaRegConfigPkg::*;
#(
    parameter int CHANNELS = dmaRegConfigPkg::CHANNELS,
    parameter int CHW      = $clog2(CHANNELS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] DREQ,
    input  logic                HLDA,
    input  logic                srvDone,
    input  logic                rotatePri,
    input  logic                dreqActiveLow,
    input  logic                dackActiveHigh,
    input  logic                ctrlDisable,
    input  logic [CHANNELS-1:0] maskReg,
    input  logic [CHANNELS-1:0] swReq,
    output logic                HRQ,
    output logic [CHANNELS-1:0] DACK,
    output logic [CHW-1:0]      activeCh,
    output logic                grantValid
);

    localparam logic [CHW-1:0]      C_LAST    = CHW'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] C_ONE_HOT = CHANNELS'(1);

    arbState_t           r_state_q,       w_state_d;
    logic                r_hrq_q,         w_hrq_d;
    logic [CHANNELS-1:0] r_gnt_q,         w_gnt_d;
    logic [CHW-1:0]      r_active_ch_q,   w_active_ch_d;
    logic                r_grant_valid_q, w_grant_valid_d;
    logic [CHW-1:0]      r_top_pri_q,     w_top_pri_d;

    logic [CHANNELS-1:0] w_eff;
    logic                w_eff_any;
    logic [CHW-1:0]      w_winner;
    logic                w_win_valid;

    // Normalise pin polarity, drop masked hardware requests, OR in software requests.
    assign w_eff     = ((DREQ ^ {CHANNELS{dreqActiveLow}}) & ~maskReg) | swReq;
    assign w_eff_any = |w_eff;

    dma_rr_priority_encoder #(
        .CHANNELS (CHANNELS),
        .CHW      (CHW)
    ) u_encoder (
        .i_eff     (w_eff),
        .i_top_pri (r_top_pri_q),
        .i_mode    (priMode_t'(rotatePri)),
        .o_winner  (w_winner),
        .o_valid   (w_win_valid)
    );

    // State register and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state_q       <= IDLE;
            r_hrq_q         <= 1'b0;
            r_gnt_q         <= '0;
            r_active_ch_q   <= '0;
            r_grant_valid_q <= 1'b0;
            r_top_pri_q     <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_hrq_q         <= w_hrq_d;
            r_gnt_q         <= w_gnt_d;
            r_active_ch_q   <= w_active_ch_d;
            r_grant_valid_q <= w_grant_valid_d;
            r_top_pri_q     <= w_top_pri_d;
        end
    end

    // Next-state and next-output logic for the hold handshake.
    always_comb begin
        w_state_d       = r_state_q;
        w_hrq_d         = r_hrq_q;
        w_gnt_d         = r_gnt_q;
        w_active_ch_d   = r_active_ch_q;
        w_grant_valid_d = r_grant_valid_q;
        w_top_pri_d     = r_top_pri_q;

        unique case (r_state_q)
            IDLE: begin
                if (w_eff_any && !ctrlDisable) begin
                    w_hrq_d   = 1'b1;
                    w_state_d = REQ;
                end
            end
            REQ: begin
                // The disable bit is deliberately not consulted once HRQ is out.
                if (HLDA && w_win_valid) begin
                    w_gnt_d         = C_ONE_HOT << w_winner;
                    w_active_ch_d   = w_winner;
                    w_grant_valid_d = 1'b1;
                    w_state_d       = GRANT;
                end else if (!w_eff_any) begin
                    w_hrq_d   = 1'b0;
                    w_state_d = HLDA ? RELEASE : IDLE;
                end
            end
            GRANT: begin
                // Grant is held against DREQ/mask changes until service ends or the host aborts.
                if (srvDone) begin
                    w_gnt_d         = '0;
                    w_hrq_d         = 1'b0;
                    w_grant_valid_d = 1'b0;
                    w_state_d       = HLDA ? RELEASE : IDLE;
                    if (rotatePri) begin
                        w_top_pri_d = (r_active_ch_q == C_LAST) ? '0 : r_active_ch_q + 1'b1;
                    end
                end else if (!HLDA) begin
                    w_gnt_d         = '0;
                    w_hrq_d         = 1'b0;
                    w_grant_valid_d = 1'b0;
                    w_state_d       = IDLE;
                end
            end
            RELEASE: begin
                // Hold HRQ low until the host lets go of the bus.
                w_hrq_d = 1'b0;
                if (!HLDA) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign HRQ        = r_hrq_q;
    assign DACK       = dackActiveHigh ? r_gnt_q : ~r_gnt_q;
    assign activeCh   = r_active_ch_q;
    assign grantValid = r_grant_valid_q;

endmodule : dma_priority_arbiter
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_priority_arbiter
//  Brief    : Self-checking bench for dma_priority_arbiter: directed
//             scenarios plus randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arbiter;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [N-1:0] DREQ = '0;
    logic         HLDA = 1'b0;
    logic         srvDone = 1'b0;
    logic         rotatePri = 1'b0;
    logic         dreqActiveLow = 1'b0;
    logic         dackActiveHigh = 1'b1;
    logic         ctrlDisable = 1'b0;
    logic [N-1:0] maskReg = '0;
    logic [N-1:0] swReq = '0;
    wire          HRQ;
    wire  [N-1:0] DACK;
    wire  [1:0]   activeCh;
    wire          grantValid;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 requesting, 2 granted, 3 releasing.
    int m_st, m_hrq, m_ch, m_act, m_gv, m_top;

    dma_priority_arbiter #(.CHANNELS(N), .CHW(2)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .DREQ           (DREQ),
        .HLDA           (HLDA),
        .srvDone        (srvDone),
        .rotatePri      (rotatePri),
        .dreqActiveLow  (dreqActiveLow),
        .dackActiveHigh (dackActiveHigh),
        .ctrlDisable    (ctrlDisable),
        .maskReg        (maskReg),
        .swReq          (swReq),
        .HRQ            (HRQ),
        .DACK           (DACK),
        .activeCh       (activeCh),
        .grantValid     (grantValid)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [N-1:0] ref_eff();
        logic [N-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++)
            e[i] = ((DREQ[i] != dreqActiveLow) && !maskReg[i]) || swReq[i];
        return e;
    endfunction

    function automatic int ref_winner(logic [N-1:0] e);
        int start;
        start = rotatePri ? m_top : 0;
        for (int k = 0; k < N; k++)
            if (e[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] ref_dack();
        logic [N-1:0] g;
        g = '0;
        if (m_ch >= 0) g[m_ch] = 1'b1;
        return dackActiveHigh ? g : ~g;
    endfunction

    task automatic model_reset();
        m_st = 0; m_hrq = 0; m_ch = -1; m_act = 0; m_gv = 0; m_top = 0;
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic tick();
        logic [N-1:0] e;
        int w, n_st, n_hrq, n_ch, n_act, n_gv, n_top;
        e = ref_eff();
        w = ref_winner(e);
        n_st = m_st; n_hrq = m_hrq; n_ch = m_ch; n_act = m_act; n_gv = m_gv; n_top = m_top;
        case (m_st)
            0: if (e != 0 && !ctrlDisable) begin n_st = 1; n_hrq = 1; end
            1: begin
                if (HLDA && e != 0) begin n_ch = w; n_act = w; n_gv = 1; n_st = 2; end
                else if (!HLDA && e == 0) begin n_hrq = 0; n_st = 0; end
                else if (HLDA && e == 0) begin n_hrq = 0; n_st = 3; end
            end
            2: begin
                if (srvDone) begin
                    n_ch = -1; n_hrq = 0; n_gv = 0;
                    if (rotatePri) n_top = (m_act + 1) % N;
                    n_st = HLDA ? 3 : 0;
                end else if (!HLDA) begin
                    n_ch = -1; n_hrq = 0; n_gv = 0; n_st = 0;
                end
            end
            default: begin n_hrq = 0; if (!HLDA) n_st = 0; end
        endcase
        @(posedge CLK);
        #1;
        m_st = n_st; m_hrq = n_hrq; m_ch = n_ch; m_act = n_act; m_gv = n_gv; m_top = n_top;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        DREQ = '0; HLDA = 1'b0; srvDone = 1'b0; rotatePri = 1'b0;
        dreqActiveLow = 1'b0; dackActiveHigh = 1'b1; ctrlDisable = 1'b0;
        maskReg = '0; swReq = '0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // Wait (bounded) for HRQ, then acknowledge the hold for one edge.
    task automatic get_grant();
        for (int i = 0; i < 8 && HRQ !== 1'b1; i++) tick();
        if (HRQ !== 1'b1) begin
            checks++; errors++;
            $display("FAIL grant_hrq_timeout: HRQ=%b required 1", HRQ);
        end
        HLDA = 1'b1;
        tick();
    endtask

    // End service normally and return the handshake to idle with no requests.
    task automatic finish_service();
        srvDone = 1'b1;
        tick();
        srvDone = 1'b0;
        HLDA = 1'b0;
        DREQ = {N{dreqActiveLow}};
        swReq = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({HRQ, DACK, activeCh, grantValid} !== 8'b0_0000_00_0) begin
            errors++;
            $display("FAIL reset_values: HRQ=%b DACK=%b activeCh=%0d gv=%b required 0/0000/0/0",
                     HRQ, DACK, activeCh, grantValid);
        end
        // Move topPri off zero, then reset in the middle of a grant on ch2.
        rotatePri = 1'b1;
        DREQ = 4'b0010;
        get_grant();
        finish_service();
        DREQ = 4'b0100;
        get_grant();
        checks++;
        if (DACK !== 4'b0100 || activeCh !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_grant: DACK=%b activeCh=%0d required 0100/2", DACK, activeCh);
        end
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({HRQ, DACK, activeCh, grantValid} !== 8'b0_0000_00_0) begin
            errors++;
            $display("FAIL async_reset: HRQ=%b DACK=%b activeCh=%0d gv=%b required 0/0000/0/0",
                     HRQ, DACK, activeCh, grantValid);
        end
        @(negedge CLK);
        RESET = 1'b0;
        HLDA = 1'b0;
        model_reset();
        DREQ = 4'b1111;
        tick();
        checks++;
        if (HRQ !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_idle: HRQ=%b required 1", HRQ);
        end
        HLDA = 1'b1;
        tick();
        checks++;
        if (activeCh !== 2'd0 || DACK !== 4'b0001) begin
            errors++;
            $display("FAIL reset_top_pri: activeCh=%0d DACK=%b required 0/0001", activeCh, DACK);
        end
        finish_service();
    endtask

    task automatic test_fixed_latency();
        do_reset();
        DREQ = 4'b1010;
        tick();
        checks++;
        if (HRQ !== 1'b1) begin
            errors++;
            $display("FAIL fixed_hrq: HRQ=%b required 1", HRQ);
        end
        tick();
        tick();
        HLDA = 1'b1;
        #1;
        checks++;
        if (DACK !== 4'b0000 || grantValid !== 1'b0) begin
            errors++;
            $display("FAIL fixed_early_dack: DACK=%b gv=%b required 0000/0", DACK, grantValid);
        end
        tick();
        checks++;
        if (DACK !== 4'b0010 || activeCh !== 2'd1 || grantValid !== 1'b1) begin
            errors++;
            $display("FAIL fixed_grant: DACK=%b activeCh=%0d gv=%b required 0010/1/1",
                     DACK, activeCh, grantValid);
        end
        finish_service();
    endtask

    task automatic test_rotating();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_dack;
        do_reset();
        rotatePri = 1'b1;
        DREQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            get_grant();
            exp_dack = 4'b0001 << exp_order[g];
            checks++;
            if (activeCh !== 2'(exp_order[g]) || DACK !== exp_dack) begin
                errors++;
                $display("FAIL rotate_order[%0d]: activeCh=%0d DACK=%b required %0d/%b",
                         g, activeCh, DACK, exp_order[g], exp_dack);
            end
            srvDone = 1'b1;
            tick();
            srvDone = 1'b0;
            HLDA = 1'b0;
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++;
                $display("FAIL rotate_hrq_gap[%0d]: HRQ=%b required 0", g, HRQ);
            end
        end
        DREQ = '0;
        tick();
        tick();
    endtask

    task automatic test_mask_swreq();
        do_reset();
        maskReg = 4'b0001;
        DREQ = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++;
                $display("FAIL masked_hrq[%0d]: HRQ=%b required 0", i, HRQ);
            end
        end
        swReq = 4'b0001;
        tick();
        checks++;
        if (HRQ !== 1'b1) begin
            errors++;
            $display("FAIL swreq_hrq: HRQ=%b required 1", HRQ);
        end
        HLDA = 1'b1;
        tick();
        checks++;
        if (DACK !== 4'b0001 || activeCh !== 2'd0) begin
            errors++;
            $display("FAIL swreq_grant: DACK=%b activeCh=%0d required 0001/0", DACK, activeCh);
        end
        finish_service();
        maskReg = '0;
    endtask

    task automatic test_polarity();
        do_reset();
        dreqActiveLow = 1'b1;
        dackActiveHigh = 1'b0;
        DREQ = 4'b1011;
        #1;
        checks++;
        if (DACK !== 4'b1111) begin
            errors++;
            $display("FAIL polarity_idle_dack: DACK=%b required 1111", DACK);
        end
        get_grant();
        checks++;
        if (DACK !== 4'b1011 || activeCh !== 2'd2) begin
            errors++;
            $display("FAIL polarity_grant: DACK=%b activeCh=%0d required 1011/2", DACK, activeCh);
        end
        finish_service();
    endtask

    task automatic test_abort();
        do_reset();
        rotatePri = 1'b1;
        DREQ = 4'b0010;
        get_grant();
        finish_service();            // topPri now 2
        DREQ = 4'b1000;
        get_grant();
        checks++;
        if (activeCh !== 2'd3) begin
            errors++;
            $display("FAIL abort_setup: activeCh=%0d required 3", activeCh);
        end
        HLDA = 1'b0;
        tick();
        checks++;
        if (DACK !== 4'b0000 || HRQ !== 1'b0 || grantValid !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: DACK=%b HRQ=%b gv=%b required 0000/0/0", DACK, HRQ, grantValid);
        end
        tick();
        checks++;
        if (HRQ !== 1'b1) begin
            errors++;
            $display("FAIL abort_to_idle: HRQ=%b required 1", HRQ);
        end
        DREQ = 4'b1111;
        HLDA = 1'b1;
        tick();
        checks++;
        if (activeCh !== 2'd2) begin
            errors++;
            $display("FAIL abort_top_pri_kept: activeCh=%0d required 2", activeCh);
        end
        finish_service();            // topPri now 3
        DREQ = 4'b1000;
        get_grant();
        srvDone = 1'b1;
        HLDA = 1'b0;
        tick();
        srvDone = 1'b0;
        checks++;
        if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
            errors++;
            $display("FAIL abort_srvdone_outputs: DACK=%b HRQ=%b required 0000/0", DACK, HRQ);
        end
        tick();
        checks++;
        if (HRQ !== 1'b1) begin
            errors++;
            $display("FAIL abort_srvdone_idle: HRQ=%b required 1", HRQ);
        end
        DREQ = 4'b1111;
        HLDA = 1'b1;
        tick();
        checks++;
        if (activeCh !== 2'd0) begin
            errors++;
            $display("FAIL abort_srvdone_wrap: activeCh=%0d required 0", activeCh);
        end
        finish_service();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_dack;
        int printed = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) DREQ = N'($urandom);
            if ($urandom_range(15) == 0) maskReg = N'($urandom);
            swReq = ($urandom_range(15) == 0) ? N'($urandom) & N'($urandom) : '0;
            if ($urandom_range(49) == 0) rotatePri = ~rotatePri;
            if ($urandom_range(99) == 0) dreqActiveLow = ~dreqActiveLow;
            if ($urandom_range(99) == 0) dackActiveHigh = ~dackActiveHigh;
            if ($urandom_range(9) == 0) ctrlDisable = ~ctrlDisable;
            if (m_hrq != 0) begin
                if (!HLDA && $urandom_range(1) == 0) HLDA = 1'b1;
                else if (HLDA && $urandom_range(29) == 0) HLDA = 1'b0;
            end else if (HLDA && $urandom_range(1) == 0) begin
                HLDA = 1'b0;
            end
            srvDone = (m_st == 2) ? ($urandom_range(4) == 0) : ($urandom_range(19) == 0);
            tick();
            exp_dack = ref_dack();
            checks++;
            if ({HRQ, DACK, activeCh, grantValid} !== {m_hrq[0], exp_dack, 2'(m_act), m_gv[0]}) begin
                errors++;
                if (printed < 10) begin
                    printed++;
                    $display("FAIL random[%0d]: HRQ=%b DACK=%b activeCh=%0d gv=%b required %0d/%b/%0d/%0d",
                             c, HRQ, DACK, activeCh, grantValid, m_hrq, exp_dack, m_act, m_gv);
                end
            end
        end
        srvDone = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fixed_latency();
        test_rotating();
        test_mask_swreq();
        test_polarity();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dma_priority_arbiter
`default_nettype wire
